pwm_ramp_gen: RTL and testbench

Multi-channel PWM generator with a shared period counter. It replaces the single-channel fixed-table speed source.
- Each channel has a programmable duty (in counts) that is double-buffered.
- Duty changes are applied only at period boundaries and slew-limited (soft start/stop), to protect motor drivers.
- Sits between the rover control FSM (targets, enables) and the H-bridge pins.

---
 rtl/pwm_pkg.sv | 33 +++
 rtl/pwm_channel.sv | 112 +++++++++++
 rtl/pwm_ramp_gen.sv | 73 +++++++
 tb/tb_pwm_ramp_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM ramp generator.
//   - default parameter values (counter width, period, slew step, channel count)
//   - ramp status enum used by each channel's status FSM
//   - clamp helper that limits a requested duty to the PWM period
package pwm_pkg;

  localparam int CHANNELS_DEF  = 2;
  localparam int CNT_W_DEF     = 20;
  localparam int PERIOD_DEF    = 1000000;
  localparam int RAMP_STEP_DEF = 65536;

  // IDLE: cur==0 and shadow==0; UP: cur<shadow; DOWN: cur>shadow; HOLD: cur==shadow!=0
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    HOLD = 2'd3
  } ramp_state_e;

  // min(x, period): targets beyond one full period saturate to 100% duty.
  // Operates on 32 bits so any counter width up to 32 can share it.
  function automatic logic [31:0] clamp_period(input logic [31:0] x,
                                               input logic [31:0] period);
    logic [31:0] r;
    if (x > period) begin
      r = period;
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow duty register, applied (slew-limited) duty,
// ramp status FSM and the registered PWM output.
//   clk, reset     system clock, synchronous active-high reset
//   load           strobe capturing duty_target (clamped) into the shadow
//   boundary       high while the shared counter sits at PERIOD-1
//   en             channel enable; low forces pwm low and, at the boundary, cur to 0
//   cnt            shared period counter
//   duty_target    requested duty in counts
//   pwm            registered PWM output
//   ramping        high while the status FSM is UP or DOWN
//   duty_cur       currently applied duty
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int PERIOD    = PERIOD_DEF,
  parameter int RAMP_STEP = RAMP_STEP_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             boundary,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] duty_target,
  output logic             pwm,
  output logic             ramping,
  output logic [CNT_W-1:0] duty_cur
);

  localparam int             STEP_W = CNT_W + 1;
  localparam logic [CNT_W:0] STEP   = STEP_W'(RAMP_STEP);

  logic [CNT_W-1:0] shadow_r;
  logic [CNT_W-1:0] cur_r;
  logic             pwm_r;
  ramp_state_e      state_r;

  logic [CNT_W-1:0] shadow_clamp_s;
  logic [CNT_W-1:0] cur_nxt_s;
  logic [CNT_W:0]   sum_s;
  logic [CNT_W:0]   diff_s;
  ramp_state_e      state_nxt_s;

  assign shadow_clamp_s = CNT_W'(clamp_period(32'(duty_target), 32'(PERIOD)));

  // Next applied duty: slew toward shadow, one extra bit so the sum never wraps
  always_comb begin
    cur_nxt_s = cur_r;
    sum_s     = {1'b0, cur_r} + STEP;
    diff_s    = {1'b0, cur_r} - {1'b0, shadow_r};
    if (!en) begin
      cur_nxt_s = '0;
    end else if (RAMP_STEP == 0) begin
      cur_nxt_s = shadow_r;
    end else if (cur_r < shadow_r) begin
      if (sum_s > {1'b0, shadow_r}) begin
        cur_nxt_s = shadow_r;
      end else begin
        cur_nxt_s = sum_s[CNT_W-1:0];
      end
    end else if (cur_r > shadow_r) begin
      // step down only while the gap exceeds one step, so cur never passes shadow
      if (diff_s > STEP) begin
        cur_nxt_s = cur_r - STEP[CNT_W-1:0];
      end else begin
        cur_nxt_s = shadow_r;
      end
    end else begin
      cur_nxt_s = cur_r;
    end
  end

  // Status after the boundary update, judged against the shadow the ramp used
  always_comb begin
    state_nxt_s = state_r;
    if (cur_nxt_s < shadow_r) begin
      state_nxt_s = UP;
    end else if (cur_nxt_s > shadow_r) begin
      state_nxt_s = DOWN;
    end else if (cur_nxt_s == '0) begin
      state_nxt_s = IDLE;
    end else begin
      state_nxt_s = HOLD;
    end
  end

  // Shadow capture, boundary-gated duty/status update and PWM output register
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_r <= '0;
      cur_r    <= '0;
      pwm_r    <= 1'b0;
      state_r  <= IDLE;
    end else begin
      if (load) begin
        shadow_r <= shadow_clamp_s;
      end
      if (boundary) begin
        cur_r   <= cur_nxt_s;
        state_r <= state_nxt_s;
      end
      // cnt < cur with cur==PERIOD is always true, so 100% duty has no wrap glitch
      pwm_r <= en && (cnt < cur_r);
    end
  end

  assign pwm      = pwm_r;
  assign ramping  = (state_r == UP) || (state_r == DOWN);
  assign duty_cur = cur_r;

endmodule

// File: rtl/pwm_ramp_gen.sv
// Multi-channel PWM generator with shared period counter and per-channel
// double-buffered, slew-limited duty.
//   clk, reset     system clock, synchronous active-high reset
//   en             per-channel enable
//   duty_target    packed targets, channel i at [i*CNT_W +: CNT_W]
//   load           strobe capturing all targets into the shadow registers
//   pwm            registered PWM outputs
//   period_start   one-cycle pulse marking the start of each PWM period
//   ramping        per-channel: applied duty still moving toward shadow
//   duty_cur       packed applied duties
module pwm_ramp_gen
  import pwm_pkg::*;
#(
  parameter int CHANNELS  = CHANNELS_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int PERIOD    = PERIOD_DEF,
  parameter int RAMP_STEP = RAMP_STEP_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*CNT_W-1:0] duty_target,
  input  logic                      load,
  output logic [CHANNELS-1:0]       pwm,
  output logic                      period_start,
  output logic [CHANNELS-1:0]       ramping,
  output logic [CHANNELS*CNT_W-1:0] duty_cur
);

  logic [CNT_W-1:0] cnt_r;
  logic             period_start_r;
  logic             boundary_s;

  assign boundary_s = (cnt_r == CNT_W'(PERIOD - 1));

  // Shared period counter; period_start is the registered decode of cnt==0,
  // so it lines up with the pwm outputs, which also lag cnt by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r          <= '0;
      period_start_r <= 1'b0;
    end else begin
      if (boundary_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      period_start_r <= (cnt_r == '0);
    end
  end

  assign period_start = period_start_r;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_channel #(
      .CNT_W     (CNT_W),
      .PERIOD    (PERIOD),
      .RAMP_STEP (RAMP_STEP)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .boundary    (boundary_s),
      .en          (en[i]),
      .cnt         (cnt_r),
      .duty_target (duty_target[i*CNT_W +: CNT_W]),
      .pwm         (pwm[i]),
      .ramping     (ramping[i]),
      .duty_cur    (duty_cur[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_pwm_ramp_gen.sv
// Directed bench for pwm_ramp_gen with PERIOD=100, RAMP_STEP=10, CHANNELS=2.
// The bench keeps its own count of the expected counter position (c) so it
// can place stimulus at exact counter values.
module tb_pwm_ramp_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  en;
  logic [39:0] duty_target;
  logic        load;
  logic [1:0]  pwm;
  logic        period_start;
  logic [1:0]  ramping;
  logic [39:0] duty_cur;

  int c;
  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  int n0, n1, k;

  int down_exp [5] = '{40, 30, 20, 10, 5};

  always #5 clk = ~clk;

  pwm_ramp_gen #(
    .CHANNELS  (2),
    .CNT_W     (20),
    .PERIOD    (100),
    .RAMP_STEP (10)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .duty_target  (duty_target),
    .load         (load),
    .pwm          (pwm),
    .period_start (period_start),
    .ramping      (ramping),
    .duty_cur     (duty_cur)
  );

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one clock: expected counter advances at the edge, then settle to the negedge
  task automatic tick();
    @(posedge clk);
    if (reset) c = 0;
    else       c = (c == 99) ? 0 : c + 1;
    @(negedge clk);
  endtask

  task automatic to_boundary();
    do tick(); while (c != 0);
  endtask

  // one full period of pwm samples; a pending load strobe is dropped after its edge
  task automatic period_count(output int h0, output int h1);
    h0 = 0;
    h1 = 0;
    repeat (100) begin
      tick();
      load = 1'b0;
      h0 += int'(pwm[0]);
      h1 += int'(pwm[1]);
    end
  endtask

  initial begin
    reset = 1'b1;
    en = 2'b00;
    load = 1'b0;
    duty_target = '0;
    c = 0;
    repeat (3) tick();
    chk("rst_pwm", 40'(pwm), 40'd0);
    chk("rst_ps", 40'(period_start), 40'd0);
    chk("rst_ramping", 40'(ramping), 40'd0);
    chk("rst_duty_cur", duty_cur, 40'd0);

    // release reset: period_start pulses on the first cycle after release
    reset = 1'b0;
    en = 2'b11;
    tick();
    chk("ps_after_release", 40'(period_start), 40'd1);
    tick();
    chk("ps_one_cycle", 40'(period_start), 40'd0);

    // ramp up to 50 on ch0, ch1 stays 0
    duty_target = {20'd0, 20'd50};
    load = 1'b1;
    tick();
    load = 1'b0;
    to_boundary();
    chk("up_cur_first", 40'(duty_cur[19:0]), 40'd10);
    chk("up_ramping_first", 40'(ramping[0]), 40'd1);
    for (int p = 1; p <= 5; p++) begin
      period_count(n0, n1);
      chk("up_pwm0_highs", 40'(n0), 40'(10 * p));
      chk("up_pwm1_zero", 40'(n1), 40'd0);
      chk("up_cur", 40'(duty_cur[19:0]), 40'((10 * (p + 1) > 50) ? 50 : 10 * (p + 1)));
      chk("up_ramping", 40'(ramping[0]), 40'((10 * (p + 1) < 50) ? 1 : 0));
    end

    // target 250 clamps to PERIOD -> constant high across the wrap
    duty_target = {20'd0, 20'd250};
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (5) to_boundary();
    chk("clamp_cur", 40'(duty_cur[19:0]), 40'd100);
    chk("clamp_ramping", 40'(ramping[0]), 40'd0);
    period_count(n0, n1);
    chk("full_pwm0_highs", 40'(n0), 40'd100);
    tick();
    chk("full_pwm0_after_wrap", 40'(pwm[0]), 40'd1);
    to_boundary();

    // back down to 50, then ramp down to 5 without underflow
    duty_target = {20'd0, 20'd50};
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (5) to_boundary();
    chk("down_to50_cur", 40'(duty_cur[19:0]), 40'd50);
    duty_target = {20'd0, 20'd5};
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int j = 0; j < 5; j++) begin
      to_boundary();
      chk("down_cur", 40'(duty_cur[19:0]), 40'(down_exp[j]));
      chk("down_ramping", 40'(ramping[0]), 40'((j < 4) ? 1 : 0));
    end

    // load 0: the period still runs at duty 5, then cur reaches 0 (IDLE)
    duty_target = '0;
    load = 1'b1;
    period_count(n0, n1);
    chk("duty5_pwm0_highs", 40'(n0), 40'd5);
    chk("zero_cur", 40'(duty_cur[19:0]), 40'd0);
    chk("zero_idle_ramping", 40'(ramping[0]), 40'd0);

    // load coincident with the boundary: ramp uses the old shadow (0)
    while (c != 99) tick();
    duty_target = {20'd0, 20'd30};
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("coinc_cur_old", 40'(duty_cur[19:0]), 40'd0);
    chk("coinc_ramping_old", 40'(ramping[0]), 40'd0);
    to_boundary();
    chk("coinc_cur_next", 40'(duty_cur[19:0]), 40'd10);
    chk("coinc_ramping_next", 40'(ramping[0]), 40'd1);

    // enable drop mid-period
    repeat (2) to_boundary();
    chk("en_cur30", 40'(duty_cur[19:0]), 40'd30);
    while (c != 20) tick();
    chk("en_pwm0_high", 40'(pwm[0]), 40'd1);
    en = 2'b10;
    tick();
    chk("en_pwm0_drop", 40'(pwm[0]), 40'd0);
    chk("en_cur_mid", 40'(duty_cur[19:0]), 40'd30);
    to_boundary();
    chk("en_cur_zero", 40'(duty_cur[19:0]), 40'd0);
    en = 2'b11;
    to_boundary();
    chk("reen_cur", 40'(duty_cur[19:0]), 40'd10);

    // reset mid-period with cur=50
    duty_target = {20'd0, 20'd50};
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (4) to_boundary();
    chk("pre_rst_cur", 40'(duty_cur[19:0]), 40'd50);
    while (c != 60) tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_pwm", 40'(pwm), 40'd0);
    chk("mid_rst_duty_cur", duty_cur, 40'd0);
    chk("mid_rst_ramping", 40'(ramping), 40'd0);
    chk("mid_rst_ps", 40'(period_start), 40'd0);
    reset = 1'b0;
    tick();
    chk("mid_rst_ps_pulse", 40'(period_start), 40'd1);
    k = 0;
    do begin
      tick();
      k++;
    end while (!period_start && k < 300);
    chk("ps_interval", 40'(k), 40'd100);
    chk("post_rst_shadow_zero", 40'(duty_cur[19:0]), 40'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
